// File: rtl/eth_framer.sv
// Ethernet II framer: prepends dst/src MAC and EtherType to a payload stream
// and zero-pads short frames up to MIN_FRAME_BYTES (FCS excluded).
module eth_framer #(
  parameter int unsigned AXIS_BYTES      = 2,
  parameter logic [47:0] OUR_MAC         = 48'h0,
  parameter logic [15:0] ETHERTYPE       = 16'h0806,
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic                    clk,
  input  logic                    sreset,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
  input  logic [47:0]             axis_i_dst_mac,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]   axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata
);

  localparam int unsigned DW        = 8 * AXIS_BYTES;
  localparam int unsigned HDR_BEATS = 14 / AXIS_BYTES;
  localparam int unsigned BW        = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_PAD     = 2'd3;

  if (!(AXIS_BYTES == 1 || AXIS_BYTES == 2)) begin : g_bad_width
    $error("eth_framer: AXIS_BYTES must be 1 or 2");
  end
  if ((MIN_FRAME_BYTES % AXIS_BYTES) != 0 || MIN_FRAME_BYTES < 14 + AXIS_BYTES) begin : g_bad_min
    $error("eth_framer: MIN_FRAME_BYTES must be a multiple of AXIS_BYTES and >= 14+AXIS_BYTES");
  end

  function automatic logic [16:0] popcnt(input logic [AXIS_BYTES-1:0] k);
    logic [16:0] s;
    s = '0;
    for (int i = 0; i < int'(AXIS_BYTES); i++) s = s + 17'(k[i]);
    return s;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] s;
    s = 17'(a) + b;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0]    state_q, state_d;
  logic [47:0]   mac_q, mac_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [111:0]  hdr_w;
  logic [16:0]   n_sum;
  logic          n_ge_min;
  logic          pad_last;
  logic [DW-1:0] data_masked;

  // Header bytes in wire order, byte 0 in the low bits.
  assign hdr_w    = {ETHERTYPE[7:0], ETHERTYPE[15:8], OUR_MAC, mac_q};
  assign n_sum    = 17'(cnt_q) + popcnt(axis_i_tkeep);
  assign n_ge_min = (n_sum >= 17'(MIN_FRAME_BYTES));
  assign pad_last = ((17'(cnt_q) + 17'(AXIS_BYTES)) == 17'(MIN_FRAME_BYTES));

  always_comb begin
    data_masked = '0;
    for (int i = 0; i < int'(AXIS_BYTES); i++) begin
      data_masked[8*i +: 8] = axis_i_tkeep[i] ? axis_i_tdata[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= S_IDLE;
      mac_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mac_q   <= mac_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mac_d         = mac_q;
    cnt_d         = cnt_q;
    beat_d        = beat_q;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tkeep  = '0;
    axis_o_tdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (axis_i_tvalid) begin
          mac_d   = axis_i_dst_mac;
          cnt_d   = '0;
          beat_d  = '0;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        axis_o_tvalid = 1'b1;
        axis_o_tkeep  = '1;
        axis_o_tdata  = hdr_w[32'(beat_q) * DW +: DW];
        if (axis_o_tready) begin
          beat_d = BW'(beat_q + BW'(1));
          if (beat_q == BW'(HDR_BEATS - 1)) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        axis_o_tvalid = axis_i_tvalid;
        axis_i_tready = axis_o_tready;
        axis_o_tdata  = axis_i_tdata;
        axis_o_tkeep  = axis_i_tkeep;
        axis_o_tlast  = axis_i_tlast & n_ge_min;
        // Short frame: the final payload beat is widened and topped up with zeros.
        if (axis_i_tlast && !n_ge_min) begin
          axis_o_tkeep = '1;
          axis_o_tdata = data_masked;
        end
        if (axis_i_tvalid && axis_o_tready && axis_i_tlast) begin
          state_d = n_ge_min ? S_IDLE : S_PAD;
        end
      end
      S_PAD: begin
        axis_o_tvalid = 1'b1;
        axis_o_tkeep  = '1;
        axis_o_tlast  = pad_last;
        if (axis_o_tready && pad_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Byte count follows what was actually emitted, so padding widens are included.
    if (axis_o_tvalid && axis_o_tready) cnt_d = sat_add(cnt_q, popcnt(axis_o_tkeep));
  end

endmodule

// File: tb/tb_eth_framer.sv
// Scoreboard bench for eth_framer: directed frames, throttled random traffic,
// and a mid-payload reset.
module tb_eth_framer;

  localparam logic [47:0] OUR = 48'hCCBBAA998877;

  logic        clk;
  logic        sreset;
  logic        axis_i_tready;
  logic        axis_i_tvalid;
  logic        axis_i_tlast;
  logic [1:0]  axis_i_tkeep;
  logic [15:0] axis_i_tdata;
  logic [47:0] axis_i_dst_mac;
  logic        axis_o_tready;
  logic        axis_o_tvalid;
  logic        axis_o_tlast;
  logic [1:0]  axis_o_tkeep;
  logic [15:0] axis_o_tdata;

  eth_framer #(
    .AXIS_BYTES(2), .OUR_MAC(OUR), .ETHERTYPE(16'h0806), .MIN_FRAME_BYTES(60)
  ) dut (
    .clk(clk), .sreset(sreset),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tkeep(axis_i_tkeep),
    .axis_i_tdata(axis_i_tdata), .axis_i_dst_mac(axis_i_dst_mac),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast(axis_o_tlast), .axis_o_tkeep(axis_o_tkeep),
    .axis_o_tdata(axis_o_tdata)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  beat_t        sb[$];
  beat_t        cap[$];
  byte unsigned pay[$];
  bit           rdy_rand = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Downstream ready: always 1, or random ~75% when throttling.
  initial begin
    axis_o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis_o_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin
    beat_t       exp;
    beat_t       got;
    logic        stall;
    logic [15:0] sd;
    logic [1:0]  sk;
    logic        sl;
    logic [15:0] km;
    int          fbytes;
    stall  = 1'b0;
    fbytes = 0;
    sd = '0; sk = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (sreset) begin
        stall  = 1'b0;
        fbytes = 0;
      end else if (axis_o_tvalid) begin
        if (stall) begin
          checks++;
          if (axis_o_tdata !== sd || axis_o_tkeep !== sk || axis_o_tlast !== sl) begin
            errors++;
            $display("FAIL stall_hold got %h/%b/%b required %h/%b/%b",
                     axis_o_tdata, axis_o_tkeep, axis_o_tlast, sd, sk, sl);
          end
        end
        if (axis_o_tready) begin
          got = '{data: axis_o_tdata, keep: axis_o_tkeep, last: axis_o_tlast};
          cap.push_back(got);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got %h/%b/%b", got.data, got.keep, got.last);
          end else begin
            exp = sb.pop_front();
            km  = {{8{exp.keep[1]}}, {8{exp.keep[0]}}};
            if ((got.data & km) !== (exp.data & km) || got.keep !== exp.keep ||
                got.last !== exp.last) begin
              errors++;
              $display("FAIL beat got %h/%b/%b required %h/%b/%b",
                       got.data, got.keep, got.last, exp.data, exp.keep, exp.last);
            end
          end
          fbytes += int'(axis_o_tkeep[0]) + int'(axis_o_tkeep[1]);
          if (axis_o_tlast) begin
            checks++;
            if (fbytes < 60) begin
              errors++;
              $display("FAIL min_len got %0d required >= 60", fbytes);
            end
            fbytes = 0;
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          sd = axis_o_tdata; sk = axis_o_tkeep; sl = axis_o_tlast;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Pushes the expected frame for pay[] and drives it; abort_beats>0 stops early.
  task automatic send_pkt(input logic [47:0] mac, input int abort_beats);
    byte unsigned fr[$];
    int           nb;
    int           t;
    logic         hs;
    beat_t        e;
    for (int i = 0; i < 6; i++) fr.push_back(mac[8*i +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(OUR[8*i +: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h06);
    foreach (pay[i]) fr.push_back(pay[i]);
    while (fr.size() < 60) fr.push_back(8'h00);
    nb = (fr.size() + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      e.data[7:0]  = fr[2*b];
      e.data[15:8] = (2*b + 1 < fr.size()) ? fr[2*b+1] : 8'h00;
      e.keep       = (2*b + 1 < fr.size()) ? 2'b11 : 2'b01;
      e.last       = (b == nb - 1);
      sb.push_back(e);
    end

    axis_i_dst_mac = mac;
    nb = (pay.size() + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      if (rdy_rand && $urandom_range(0, 3) == 0) begin
        axis_i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      axis_i_tvalid      = 1'b1;
      axis_i_tdata[7:0]  = pay[2*k];
      axis_i_tdata[15:8] = (2*k + 1 < pay.size()) ? pay[2*k+1] : 8'hAB;
      axis_i_tkeep       = (2*k + 1 < pay.size()) ? 2'b11 : 2'b01;
      axis_i_tlast       = (k == nb - 1);
      t = 0;
      do begin
        @(negedge clk);
        hs = axis_i_tready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL input_handshake_timeout beat %0d", k);
        axis_i_tvalid = 1'b0;
        return;
      end
      if (abort_beats > 0 && k + 1 == abort_beats) return;
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic make_pay(input int n, input byte unsigned seed);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(seed + 8'(i * 7)));
  endtask

  initial begin
    sreset = 1'b1;
    axis_i_tvalid = 1'b1;
    axis_i_tlast = 1'b0;
    axis_i_tkeep = 2'b11;
    axis_i_tdata = '0;
    axis_i_dst_mac = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("rst_i_tready", 32'(axis_i_tready), 32'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    axis_i_tvalid = 1'b0;
    @(negedge clk);
    chk("idle_o_tvalid", 32'(axis_o_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // 28-byte ARP reply
    make_pay(28, 8'h30);
    cap.delete();
    send_pkt(48'h665544332211, 0);
    drain();
    chk("arp_beats", 32'(cap.size()), 32'd30);
    if (cap.size() == 30) begin
      chk("arp_beat0", 32'(cap[0].data), 32'h2211);
      chk("arp_ethertype", 32'(cap[6].data), 32'h0608);
      chk("arp_beat21_pad", 32'(cap[21].data), 32'h0000);
      chk("arp_beat28_last", 32'(cap[28].last), 32'd0);
      chk("arp_beat29_last", 32'(cap[29].last), 32'd1);
    end

    // 46-byte payload: exactly minimum length
    make_pay(46, 8'h51);
    cap.delete();
    send_pkt(48'h0A0B0C0D0E0F, 0);
    drain();
    chk("p46_beats", 32'(cap.size()), 32'd30);
    if (cap.size() == 30) chk("p46_last", 32'({cap[29].last, cap[29].keep}), 32'b111);

    // 47-byte payload: one byte over, partial last beat
    make_pay(47, 8'h77);
    cap.delete();
    send_pkt(48'h112233445566, 0);
    drain();
    chk("p47_beats", 32'(cap.size()), 32'd31);
    if (cap.size() == 31) chk("p47_last", 32'({cap[30].last, cap[30].keep}), 32'b101);

    // 29-byte payload: partial last beat widened and masked
    make_pay(29, 8'h10);
    pay[28] = 8'hCD;
    cap.delete();
    send_pkt(48'hFEDCBA987654, 0);
    drain();
    chk("p29_beats", 32'(cap.size()), 32'd30);
    if (cap.size() == 30) begin
      chk("p29_mask_beat", 32'({cap[21].data, cap[21].keep, cap[21].last}), 32'({16'h00CD, 2'b11, 1'b0}));
      chk("p29_last", 32'(cap[29].last), 32'd1);
    end

    // Throttled random traffic
    rdy_rand = 1'b1;
    for (int p = 0; p < 200; p++) begin
      pay.delete();
      for (int i = 0, n = $urandom_range(1, 100); i < n; i++) pay.push_back(8'($urandom));
      send_pkt({$urandom, $urandom}[47:0], 0);
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-payload, then a fresh frame
    make_pay(40, 8'h99);
    send_pkt(48'h010203040506, 5);
    sreset = 1'b1;
    axis_i_tvalid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    chk("rst_mid_o_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("rst_mid_i_tready", 32'(axis_i_tready), 32'd0);
    @(posedge clk);
    #1;
    make_pay(20, 8'h42);
    cap.delete();
    send_pkt(48'hA1A2A3A4A5A6, 0);
    drain();
    chk("post_rst_beats", 32'(cap.size()), 32'd30);
    if (cap.size() == 30) chk("post_rst_beat0", 32'(cap[0].data), 32'hA5A6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_framer.md
Name: eth_framer

Overview:
- Downstream stage of the ARP engine. Consumes a packed payload AXIS stream plus a per-packet destination MAC sideband.
- Emits a complete Ethernet II frame on its output stream: 14-byte header (dst MAC, OUR_MAC, ETHERTYPE), then the payload, then zero padding up to MIN_FRAME_BYTES. FCS is not included.
- Output feeds the MAC/FCS-insertion stage.

Parameters:
- AXIS_BYTES, 2, bytes per beat. Legal values are 1 or 2; any other value must fail elaboration.
- OUR_MAC, 48'h0, source MAC. Bits [7:0] are the first byte on the wire.
- ETHERTYPE, 16'h0806, EtherType in numeric form. Bits [15:8] go on the wire first.
- MIN_FRAME_BYTES, 60, minimum frame length excluding FCS. Must be a multiple of AXIS_BYTES and at least 14+AXIS_BYTES.

Ports:
- clk  in  1  clock
- sreset  in  1  synchronous reset, active-high
- axis_i_tready  out  1  payload ready
- axis_i_tvalid  in  1  payload valid
- axis_i_tlast  in  1  last payload beat
- axis_i_tkeep  in  AXIS_BYTES  byte enables; packed, and only the last beat may be partial
- axis_i_tdata  in  8*AXIS_BYTES  payload; byte 0 is in [7:0] and is first on the wire
- axis_i_dst_mac  in  48  destination MAC, [7:0] first on the wire; must be valid with the first payload beat
- axis_o_tready  in  1  frame ready
- axis_o_tvalid  out  1  frame valid
- axis_o_tlast  out  1  last frame beat
- axis_o_tkeep  out  AXIS_BYTES  byte enables
- axis_o_tdata  out  8*AXIS_BYTES  frame data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on sreset.
- Reset values: state=IDLE; axis_o_tvalid=0; axis_i_tready=0; byte count=0; latched MAC=0.
- Reset mid-frame: enter IDLE on the next edge with no further output. Any partially emitted frame is truncated without tlast. Downstream tolerates this because it is reset by the same sreset.
- Frame byte order: dst_mac[7:0..47:40], OUR_MAC[7:0..47:40], ETHERTYPE[15:8], ETHERTYPE[7:0], payload, zeros.
- Byte counter: 16 bits, counts frame bytes emitted (header + payload + pad), saturates at 16'hFFFF. It advances by popcount(tkeep) on each output handshake.
- IDLE:
  - axis_i_tready=0, axis_o_tvalid=0.
  - When axis_i_tvalid=1, latch axis_i_dst_mac, clear the count, and go to HEADER. The first payload beat is not consumed.
- HEADER:
  - axis_o_tvalid=1, tkeep all ones, tlast=0, axis_i_tready=0.
  - Emits 14/AXIS_BYTES beats from the latched header; a beat index advances only on handshake.
  - After the final header handshake, go to PAYLOAD.
  - The first header beat is valid the cycle after axis_i_tvalid is seen in IDLE (1-cycle latency).
- PAYLOAD (combinational pass-through):
  - axis_o_tvalid=axis_i_tvalid; axis_i_tready=axis_o_tready; tdata and tkeep passed through.
  - On a handshake with axis_i_tlast=1, let N = count + popcount(tkeep).
    - If N >= MIN_FRAME_BYTES: axis_o_tlast=1, tkeep passed unchanged, go to IDLE.
    - Otherwise: axis_o_tlast=0, tkeep forced all ones, bytes whose keep was 0 are driven 0 in tdata, go to PAD.
  - Non-last beats: tlast=0.
- PAD:
  - axis_o_tvalid=1, tdata=0, tkeep all ones, axis_i_tready=0.
  - tlast=1 on the beat where count+AXIS_BYTES == MIN_FRAME_BYTES; after that handshake go to IDLE.
- Back-to-back packets: the next packet's IDLE→HEADER transition takes one cycle. Throughput is therefore one bubble per frame.
- axis_o_tdata and axis_o_tkeep hold steady while tvalid=1 and tready=0, in every state.
- No other states. Any illegal encoding returns to IDLE.

Test Plan:
- 28-byte ARP reply, AXIS_BYTES=2, dst_mac=48'h665544332211, OUR_MAC=48'hCCBBAA998877, tready held 1 -> 30 beats.
  - First beat tdata=16'h2211, beat 6 (ETHERTYPE) tdata=16'h0608.
  - Beats 7-20 carry the payload; beats 21-29 are zero.
  - tlast only on beat 29; all tkeep=2'b11.
- 46-byte payload -> exactly 30 beats, no PAD state entered, input tlast mapped to output tlast.
- 47-byte payload -> 31 beats; last beat tkeep=2'b01 and tlast=1; total 61 bytes.
- 29-byte payload with last tkeep=2'b01 and data 16'hABCD on that beat -> that beat is output as 16'h00CD with tkeep=2'b11 and tlast=0, followed by 8 zero beats, tlast on the 30th beat.
- Random tready/tvalid throttling over 200 packets of 1–100 bytes -> output byte stream matches the model exactly. tdata/tkeep stay stable under stall, and no frame is shorter than 60 bytes.
- sreset asserted for 1 cycle mid-PAYLOAD -> next cycle axis_o_tvalid=0 and axis_i_tready=0. The next packet (new dst_mac) is framed correctly from a fresh header.
